// File: rtl/mdu_issue_control_pkg.sv
// Shared MDU definitions: operation encoding, issue-control FSM states and
// operation-class helpers used by the issue control block and the MDU.
package mdu_issue_control_pkg;

  typedef enum logic [2:0] {
    MDU_READ_HI     = 3'd0,
    MDU_READ_LO     = 3'd1,
    MDU_WRITE_HI    = 3'd2,
    MDU_WRITE_LO    = 3'd3,
    MDU_START_MULT  = 3'd4,
    MDU_START_MULTU = 3'd5,
    MDU_START_DIV   = 3'd6,
    MDU_START_DIVU  = 3'd7
  } mdu_operation_t;

  // Reading HI has no side effect on the MDU, so it is the idle drive value
  localparam mdu_operation_t MDU_NEUTRAL_OP = MDU_READ_HI;

  localparam int unsigned ST_W = 2;
  localparam logic [ST_W-1:0] ST_IDLE      = 2'd0;
  localparam logic [ST_W-1:0] ST_WAIT      = 2'd1;
  localparam logic [ST_W-1:0] ST_READ_DONE = 2'd2;

  function automatic logic op_is_start(input mdu_operation_t op);
    return op inside {MDU_START_MULT, MDU_START_MULTU, MDU_START_DIV, MDU_START_DIVU};
  endfunction

  function automatic logic op_is_read(input mdu_operation_t op);
    return op inside {MDU_READ_HI, MDU_READ_LO};
  endfunction

endpackage

// File: rtl/mdu_issue_control_if.sv
// Pipeline-side and MDU-side signals of the MDU issue control block.
// slave = issue control view, master = pipeline/MDU (or bench) view.
interface mdu_issue_control_if
  import mdu_issue_control_pkg::*;
#(
  parameter int unsigned DATA_W = 32
);

  logic              valid;
  mdu_operation_t    op;
  logic [DATA_W-1:0] rsValue;
  logic [DATA_W-1:0] rtValue;
  logic              flush;
  logic              mduBusy;
  logic [DATA_W-1:0] mduDataRead;
  logic [DATA_W-1:0] mduOperand1;
  logic [DATA_W-1:0] mduOperand2;
  mdu_operation_t    mduOperation;
  logic              mduStart;
  logic              stall;
  logic              resultValid;
  logic [DATA_W-1:0] result;
  logic              hang;

  modport slave (
    input  valid, op, rsValue, rtValue, flush, mduBusy, mduDataRead,
    output mduOperand1, mduOperand2, mduOperation, mduStart, stall,
           resultValid, result, hang
  );

  modport master (
    output valid, op, rsValue, rtValue, flush, mduBusy, mduDataRead,
    input  mduOperand1, mduOperand2, mduOperation, mduStart, stall,
           resultValid, result, hang
  );

endinterface

// File: rtl/mdu_request_buffer.sv
// One-entry holding register for an MDU request that must wait on mduBusy.
module mdu_request_buffer
  import mdu_issue_control_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_load,
  input  logic              i_clear,
  input  mdu_operation_t    i_op,
  input  logic [DATA_W-1:0] i_rs,
  input  logic [DATA_W-1:0] i_rt,
  output logic              o_valid,
  output mdu_operation_t    o_op,
  output logic [DATA_W-1:0] o_rs,
  output logic [DATA_W-1:0] o_rt
);

  logic              r_valid;
  mdu_operation_t    r_op;
  logic [DATA_W-1:0] r_rs;
  logic [DATA_W-1:0] r_rt;

  // Clear wins over load so a flush can never leave a stale request behind
  always_ff @(posedge clock) begin
    if (!reset || i_clear) begin
      r_valid <= 1'b0;
      r_op    <= MDU_NEUTRAL_OP;
      r_rs    <= '0;
      r_rt    <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_op    <= i_op;
      r_rs    <= i_rs;
      r_rt    <= i_rt;
    end
  end

  assign o_valid = r_valid;
  assign o_op    = r_op;
  assign o_rs    = r_rs;
  assign o_rt    = r_rt;

endmodule

// File: rtl/mdu_issue_control.sv
// Execute-stage MDU issue control: holds requests while the MDU is busy and
// returns MFHI/MFLO data. Define MDU_ISSUE_STATS_EN for stall/issue counters.
module mdu_issue_control
  import mdu_issue_control_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 31,
  parameter int unsigned DATA_W   = 32
) (
  input  logic                clock,
  input  logic                reset,
  mdu_issue_control_if.slave  bus
`ifdef MDU_ISSUE_STATS_EN
  ,
  output logic [31:0]         stallCycles,
  output logic [31:0]         issueCount
`endif
);

  localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

  logic [ST_W-1:0]   r_state;
  logic [ST_W-1:0]   w_state_nxt;
  logic [CNT_W-1:0]  r_wait_cnt;
  logic [CNT_W-1:0]  w_wait_cnt_nxt;
  logic              r_hang;
  logic              r_result_valid;
  logic [DATA_W-1:0] r_result;

  logic              w_buf_valid;
  mdu_operation_t    w_buf_op;
  logic [DATA_W-1:0] w_buf_rs;
  logic [DATA_W-1:0] w_buf_rt;
  logic              w_buf_load;
  logic              w_buf_clear;

  logic              w_req_valid;
  mdu_operation_t    w_req_op;
  logic [DATA_W-1:0] w_req_rs;
  logic [DATA_W-1:0] w_req_rt;
  logic              w_issue;
  logic              w_issue_read;

  mdu_request_buffer #(.DATA_W(DATA_W)) u_req_buf (
    .clock   (clock),
    .reset   (reset),
    .i_load  (w_buf_load),
    .i_clear (w_buf_clear),
    .i_op    (bus.op),
    .i_rs    (bus.rsValue),
    .i_rt    (bus.rtValue),
    .o_valid (w_buf_valid),
    .o_op    (w_buf_op),
    .o_rs    (w_buf_rs),
    .o_rt    (w_buf_rt)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and MDU/pipeline drive; WAIT serves the buffer, other states the pipeline
  always_comb begin
    w_state_nxt      = r_state;
    w_buf_load       = 1'b0;
    w_buf_clear      = 1'b0;
    w_issue          = 1'b0;
    w_issue_read     = 1'b0;
    bus.mduOperand1  = '0;
    bus.mduOperand2  = '0;
    bus.mduOperation = MDU_NEUTRAL_OP;
    bus.mduStart     = 1'b0;
    bus.stall        = 1'b0;

    if (r_state == ST_WAIT) begin
      w_req_valid = w_buf_valid;
      w_req_op    = w_buf_op;
      w_req_rs    = w_buf_rs;
      w_req_rt    = w_buf_rt;
    end else begin
      w_req_valid = bus.valid;
      w_req_op    = bus.op;
      w_req_rs    = bus.rsValue;
      w_req_rt    = bus.rtValue;
    end

    if (!reset) begin
      w_state_nxt = ST_IDLE;
    end else if (bus.flush) begin
      w_state_nxt = ST_IDLE;
      w_buf_clear = 1'b1;
    end else if (w_req_valid) begin
      if (bus.mduBusy) begin
        bus.stall   = 1'b1;
        w_buf_load  = (r_state != ST_WAIT);
        w_state_nxt = ST_WAIT;
      end else begin
        w_issue          = 1'b1;
        w_buf_clear      = 1'b1;
        bus.mduOperation = w_req_op;
        bus.mduOperand1  = w_req_rs;
        bus.mduOperand2  = w_req_rt;
        bus.mduStart     = op_is_start(w_req_op);
        if (op_is_read(w_req_op)) begin
          bus.stall    = 1'b1;
          w_issue_read = 1'b1;
          w_state_nxt  = ST_READ_DONE;
        end else begin
          w_state_nxt  = ST_IDLE;
        end
      end
    end else begin
      w_state_nxt = ST_IDLE;
    end
  end

  // Wait counter only advances while parked in WAIT and saturates at MAX_WAIT
  always_comb begin
    w_wait_cnt_nxt = r_wait_cnt;
    if (w_issue || bus.flush) begin
      w_wait_cnt_nxt = '0;
    end else if (r_state == ST_WAIT && r_wait_cnt != CNT_W'(MAX_WAIT)) begin
      w_wait_cnt_nxt = r_wait_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_wait_cnt     <= '0;
      r_hang         <= 1'b0;
      r_result_valid <= 1'b0;
      r_result       <= '0;
    end else begin
      r_wait_cnt     <= w_wait_cnt_nxt;
      r_result_valid <= w_issue_read;
      if (w_issue_read) begin
        r_result <= bus.mduDataRead;
      end
      if (w_wait_cnt_nxt == CNT_W'(MAX_WAIT)) begin
        r_hang <= 1'b1;
      end
    end
  end

  // A flush in READ_DONE squashes the instruction, so its result is withheld
  assign bus.resultValid = r_result_valid && !bus.flush;
  assign bus.result      = r_result;
  assign bus.hang        = r_hang;

`ifdef MDU_ISSUE_STATS_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_issue_count;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_stall_cycles <= '0;
      r_issue_count  <= '0;
    end else begin
      if (bus.stall && r_stall_cycles != 32'hFFFF_FFFF) begin
        r_stall_cycles <= r_stall_cycles + 32'd1;
      end
      if (bus.mduStart) begin
        r_issue_count <= r_issue_count + 32'd1;
      end
    end
  end

  assign stallCycles = r_stall_cycles;
  assign issueCount  = r_issue_count;
`endif

endmodule

// File: tb/tb_mdu_issue_control.sv
// Directed bench for mdu_issue_control with a behavioural MDU and a result scoreboard.
module tb_mdu_issue_control;
  import mdu_issue_control_pkg::*;

  localparam int unsigned MAX_WAIT = 31;
  localparam int          MDU_LAT  = 10;

  logic clock;
  logic reset;
  logic force_busy;

  mdu_issue_control_if #(.DATA_W(32)) bus ();

  mdu_issue_control #(.MAX_WAIT(MAX_WAIT), .DATA_W(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  logic [31:0] sb_q[$];
  logic [31:0] sb_exp;

  // Behavioural MDU: busy for MDU_LAT cycles after start, junk data while busy
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  int          m_busy_cnt = 0;

  assign bus.mduBusy     = (m_busy_cnt != 0) || force_busy;
  assign bus.mduDataRead = bus.mduBusy ? 32'hBAD0_BAD0 :
                           (bus.mduOperation == MDU_READ_LO) ? m_lo : m_hi;

  always @(posedge clock) begin
    if (bus.mduStart) begin
      m_busy_cnt <= MDU_LAT;
      case (bus.mduOperation)
        MDU_START_MULT:  {m_hi, m_lo} <= $signed({{32{bus.mduOperand1[31]}}, bus.mduOperand1}) *
                                         $signed({{32{bus.mduOperand2[31]}}, bus.mduOperand2});
        MDU_START_MULTU: {m_hi, m_lo} <= {32'd0, bus.mduOperand1} * {32'd0, bus.mduOperand2};
        MDU_START_DIV: begin
          m_lo <= $signed(bus.mduOperand1) / $signed(bus.mduOperand2);
          m_hi <= $signed(bus.mduOperand1) % $signed(bus.mduOperand2);
        end
        MDU_START_DIVU: begin
          m_lo <= bus.mduOperand1 / bus.mduOperand2;
          m_hi <= bus.mduOperand1 % bus.mduOperand2;
        end
        default: ;
      endcase
    end else begin
      if (m_busy_cnt != 0) m_busy_cnt <= m_busy_cnt - 1;
      if (bus.mduOperation == MDU_WRITE_HI) m_hi <= bus.mduOperand1;
      if (bus.mduOperation == MDU_WRITE_LO) m_lo <= bus.mduOperand1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input mdu_operation_t o, input logic [31:0] a, input logic [31:0] b);
    bus.valid   = v;
    bus.op      = o;
    bus.rsValue = a;
    bus.rtValue = b;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 40 && bus.mduBusy; i++) next_cycle();
    @(negedge clock);
    chk(tag, 32'(bus.mduBusy), 32'd0);
  endtask

  // Scoreboard pop on every returned result; also guard against issuing into a busy MDU
  always @(negedge clock) begin
    if (reset) begin
      chk("issue_while_busy", 32'(bus.mduBusy && bus.mduOperation != MDU_NEUTRAL_OP), 32'd0);
      if (bus.resultValid) begin
        chk("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
          sb_exp = sb_q.pop_front();
          chk("sb_result", bus.result, sb_exp);
        end
      end
    end
  end

  int stall_cnt;
  int writes;
  int starts;
  logic found;
  logic issued;

  initial begin
    reset      = 1'b0;
    force_busy = 1'b0;
    bus.flush  = 1'b0;
    drive(1'b0, MDU_READ_HI, '0, '0);
    repeat (2) next_cycle();
    @(negedge clock);
    chk("rst_stall", 32'(bus.stall), 32'd0);
    chk("rst_start", 32'(bus.mduStart), 32'd0);
    chk("rst_result_valid", 32'(bus.resultValid), 32'd0);
    chk("rst_result", bus.result, 32'd0);
    chk("rst_hang", 32'(bus.hang), 32'd0);
    chk("rst_neutral_op", 32'(bus.mduOperation), 32'(MDU_NEUTRAL_OP));

    // MULT 7 * -3 issued straight from IDLE
    next_cycle(); reset = 1'b1;
    drive(1'b1, MDU_START_MULT, 32'd7, 32'hFFFF_FFFD);
    @(negedge clock);
    chk("mult_start", 32'(bus.mduStart), 32'd1);
    chk("mult_opcode", 32'(bus.mduOperation), 32'(MDU_START_MULT));
    chk("mult_op1", bus.mduOperand1, 32'd7);
    chk("mult_op2", bus.mduOperand2, 32'hFFFF_FFFD);
    chk("mult_stall", 32'(bus.stall), 32'd0);
    next_cycle(); drive(1'b0, MDU_READ_HI, '0, '0);
    @(negedge clock);
    chk("mult_busy_onset", 32'(bus.mduBusy), 32'd1);
    chk("idle_stall", 32'(bus.stall), 32'd0);
    chk("idle_neutral", 32'(bus.mduOperation), 32'(MDU_NEUTRAL_OP));
    wait_idle("mult_idle");

    // MFLO then back-to-back MFHI
    next_cycle(); drive(1'b1, MDU_READ_LO, '0, '0); sb_q.push_back(32'hFFFF_FFEB);
    @(negedge clock);
    chk("mflo_stall", 32'(bus.stall), 32'd1);
    chk("mflo_opcode", 32'(bus.mduOperation), 32'(MDU_READ_LO));
    next_cycle(); drive(1'b1, MDU_READ_HI, '0, '0); sb_q.push_back(32'hFFFF_FFFF);
    @(negedge clock);
    chk("b2b_valid", 32'(bus.resultValid), 32'd1);
    chk("b2b_stall", 32'(bus.stall), 32'd1);
    next_cycle(); drive(1'b0, MDU_READ_HI, '0, '0);
    @(negedge clock);
    chk("mfhi_valid", 32'(bus.resultValid), 32'd1);
    chk("mfhi_done_stall", 32'(bus.stall), 32'd0);
    next_cycle();
    @(negedge clock);
    chk("valid_pulse_end", 32'(bus.resultValid), 32'd0);

    // DIVU 100/7 then MFLO in the very next cycle
    next_cycle(); drive(1'b1, MDU_START_DIVU, 32'd100, 32'd7);
    @(negedge clock);
    chk("divu_start", 32'(bus.mduStart), 32'd1);
    next_cycle(); drive(1'b1, MDU_READ_LO, '0, '0); sb_q.push_back(32'd14);
    @(negedge clock);
    chk("divu_mflo_stall", 32'(bus.stall), 32'd1);
    chk("divu_mflo_neutral", 32'(bus.mduOperation), 32'(MDU_NEUTRAL_OP));
    stall_cnt = 1;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      next_cycle();
      @(negedge clock);
      if (bus.stall) stall_cnt++;
      if (bus.mduOperation == MDU_READ_LO) begin
        found = 1'b1;
        chk("divu_read_when_idle", 32'(bus.mduBusy), 32'd0);
      end
    end
    chk("divu_read_seen", 32'(found), 32'd1);
    chk("divu_stall_cycles", 32'(stall_cnt), 32'(MDU_LAT + 1));
    next_cycle(); drive(1'b0, MDU_READ_HI, '0, '0);
    @(negedge clock);
    chk("divu_result_valid", 32'(bus.resultValid), 32'd1);
    chk("divu_done_stall", 32'(bus.stall), 32'd0);

    // MTHI while busy: exactly one WRITE_HI, only once idle
    wait_idle("multu_idle");
    next_cycle(); drive(1'b1, MDU_START_MULTU, 32'd2, 32'd3);
    @(negedge clock);
    chk("multu_start", 32'(bus.mduStart), 32'd1);
    next_cycle(); drive(1'b1, MDU_WRITE_HI, 32'hDEAD_BEEF, '0);
    @(negedge clock);
    chk("mthi_stall", 32'(bus.stall), 32'd1);
    writes = 0;
    issued = 1'b0;
    for (int i = 0; i < 16; i++) begin
      next_cycle();
      if (issued) drive(1'b0, MDU_READ_HI, '0, '0);
      @(negedge clock);
      if (bus.mduOperation == MDU_WRITE_HI) begin
        writes++;
        issued = 1'b1;
        chk("mthi_stall_issue", 32'(bus.stall), 32'd0);
        chk("mthi_no_start", 32'(bus.mduStart), 32'd0);
        chk("mthi_data", bus.mduOperand1, 32'hDEAD_BEEF);
      end else begin
        chk("mthi_neutral", 32'(bus.mduOperation), 32'(MDU_NEUTRAL_OP));
      end
    end
    chk("mthi_write_count", 32'(writes), 32'd1);
    next_cycle(); drive(1'b1, MDU_READ_HI, '0, '0); sb_q.push_back(32'hDEAD_BEEF);
    next_cycle(); drive(1'b1, MDU_READ_LO, '0, '0); sb_q.push_back(32'd6);
    next_cycle(); drive(1'b0, MDU_READ_HI, '0, '0);

    // Flush while WAIT holds a DIV
    wait_idle("flush_pre_idle");
    next_cycle(); drive(1'b1, MDU_START_MULT, 32'd5, 32'd6);
    next_cycle(); drive(1'b1, MDU_START_DIV, 32'd100, 32'd4);
    @(negedge clock);
    chk("div_wait_stall", 32'(bus.stall), 32'd1);
    next_cycle();
    @(negedge clock);
    chk("div_wait_hold", 32'(bus.stall), 32'd1);
    next_cycle(); bus.flush = 1'b1;
    @(negedge clock);
    chk("flush_stall", 32'(bus.stall), 32'd0);
    chk("flush_start", 32'(bus.mduStart), 32'd0);
    next_cycle(); bus.flush = 1'b0; drive(1'b0, MDU_READ_HI, '0, '0);
    @(negedge clock);
    chk("post_flush_stall", 32'(bus.stall), 32'd0);
    starts = 0;
    for (int i = 0; i < 15; i++) begin
      next_cycle();
      @(negedge clock);
      if (bus.mduStart) starts++;
    end
    chk("flushed_div_starts", 32'(starts), 32'd0);
    next_cycle(); drive(1'b1, MDU_READ_LO, '0, '0); sb_q.push_back(32'd30);
    next_cycle(); drive(1'b0, MDU_READ_HI, '0, '0);

    // Flush in READ_DONE withholds the result
    next_cycle(); drive(1'b1, MDU_READ_HI, '0, '0);
    next_cycle(); drive(1'b0, MDU_READ_HI, '0, '0); bus.flush = 1'b1;
    @(negedge clock);
    chk("flush_rd_valid", 32'(bus.resultValid), 32'd0);
    next_cycle(); bus.flush = 1'b0;
    @(negedge clock);
    chk("flush_rd_after", 32'(bus.resultValid), 32'd0);

    // Hang: MULT parked behind a stuck busy for MAX_WAIT+2 cycles
    wait_idle("hang_pre_idle");
    next_cycle(); force_busy = 1'b1; drive(1'b1, MDU_START_MULT, 32'd9, 32'd9);
    @(negedge clock);
    chk("hang_latch_stall", 32'(bus.stall), 32'd1);
    starts = 0;
    for (int k = 1; k <= int'(MAX_WAIT) + 1; k++) begin
      next_cycle();
      @(negedge clock);
      if (bus.mduStart) starts++;
      if (k == int'(MAX_WAIT) - 1) chk("hang_early", 32'(bus.hang), 32'd0);
      if (k == int'(MAX_WAIT) + 1) chk("hang_set", 32'(bus.hang), 32'd1);
    end
    chk("hang_no_start", 32'(starts), 32'd0);
    next_cycle(); force_busy = 1'b0;
    @(negedge clock);
    chk("hang_release_start", 32'(bus.mduStart), 32'd1);
    chk("hang_sticky", 32'(bus.hang), 32'd1);
    next_cycle(); drive(1'b0, MDU_READ_HI, '0, '0);
    @(negedge clock);
    chk("hang_sticky_idle", 32'(bus.hang), 32'd1);
    next_cycle(); reset = 1'b0;
    @(negedge clock);
    chk("hang_rst_stall", 32'(bus.stall), 32'd0);
    next_cycle(); reset = 1'b1;
    @(negedge clock);
    chk("hang_cleared", 32'(bus.hang), 32'd0);

    // Reset in the middle of WAIT
    wait_idle("rst_pre_idle");
    next_cycle(); drive(1'b1, MDU_START_MULT, 32'd1, 32'd1);
    next_cycle(); drive(1'b1, MDU_START_DIV, 32'd8, 32'd2);
    @(negedge clock);
    chk("rst_wait_stall", 32'(bus.stall), 32'd1);
    next_cycle(); reset = 1'b0;
    @(negedge clock);
    chk("rst_mid_stall", 32'(bus.stall), 32'd0);
    chk("rst_mid_start", 32'(bus.mduStart), 32'd0);
    next_cycle(); reset = 1'b1; drive(1'b0, MDU_READ_HI, '0, '0);
    @(negedge clock);
    chk("rst_after_stall", 32'(bus.stall), 32'd0);
    chk("rst_after_valid", 32'(bus.resultValid), 32'd0);
    chk("rst_after_hang", 32'(bus.hang), 32'd0);
    starts = 0;
    for (int i = 0; i < 15; i++) begin
      next_cycle();
      @(negedge clock);
      if (bus.mduStart) starts++;
    end
    chk("rst_buffer_empty", 32'(starts), 32'd0);
    next_cycle(); drive(1'b1, MDU_READ_LO, '0, '0); sb_q.push_back(32'd1);
    next_cycle(); drive(1'b0, MDU_READ_HI, '0, '0);

    next_cycle();
    @(negedge clock);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
